bit_serial_adder: RTL and testbench

BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

---
 rtl/bit_serial_adder.sv | 133 +++++++++++++
 tb/tb_bit_serial_adder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_adder.sv
// Bit-serial ripple adder: one full-adder cell processes one bit per clock,
// LSB first, under a three-state IDLE/RUN/DONE controller.
`timescale 1ns/1ps

module one_bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   psum_q, psum_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic fa_s;
  logic fa_cout;

  one_bit_full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // NOTE: every always_comb output gets its hold value first, so no path
  // through the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Sum bits enter at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
        psum_d  = {fa_s, psum_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          sum_d   = {fa_s, psum_q[WIDTH-1:1]};
          cout_d  = fa_cout;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is
  // synchronous and clears every register, datapath included.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Status decodes straight from the state register, so it is glitch-free.
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench: cycle-level result/timing model for an 8-bit adder
// plus an exhaustive sweep of a 4-bit instance.
`timescale 1ns/1ps

module tb_bit_serial_adder;
  localparam int W8 = 8;
  localparam int W4 = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start8, cin8;
  logic [W8-1:0] a8, b8;
  logic          busy8, done8, cout8;
  logic [W8-1:0] sum8;
  logic          start4, cin4;
  logic [W4-1:0] a4, b4;
  logic          busy4, done4, cout4;
  logic [W4-1:0] sum4;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(W8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  bit_serial_adder #(.WIDTH(W4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted operation keeps the block occupied for WIDTH+1 edges;
  // the result a+b+cin becomes visible on the last of those edges.
  int          m_left = 0;
  logic [W8:0] m_res = '0;
  logic [W8:0] m_out = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = 0;
      m_out  = '0;
    end else if (m_left == 0) begin
      if (start8) begin
        m_left = W8 + 1;
        m_res  = {1'b0, a8} + {1'b0, b8} + {{W8{1'b0}}, cin8};
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 1) m_out = m_res;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",  {31'd0, busy8}, {31'd0, m_left > 0});
      check("done",  {31'd0, done8}, {31'd0, m_left == 1});
      check("sum",   {24'd0, sum8},  {24'd0, m_out[W8-1:0]});
      check("cout",  {31'd0, cout8}, {31'd0, m_out[W8]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    while (!done8 && n < 40) begin
      tick();
      n++;
    end
    if (!done8) check("done8_timeout", 32'd0, 32'd1);
  endtask

  // Issue one 8-bit add from IDLE, check latency and literal results.
  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input logic [7:0] exp_sum, input logic exp_cout);
    int n;
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = ~av; b8 = ~bv; cin8 = ~cv;
    wait_done8(n);
    check("latency",    n, W8);
    check("lit_sum",    {24'd0, sum8}, {24'd0, exp_sum});
    check("lit_cout",   {31'd0, cout8}, {31'd0, exp_cout});
    check("model_pin",  {23'd0, m_out}, {23'd0, exp_cout, exp_sum});
    tick();
    check("idle_after", {31'd0, busy8}, 32'd0);
  endtask

  initial begin
    int n, last, pulses;
    rst_n = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (3) tick();
    chk_en = 1'b1;
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_sum",  {24'd0, sum8},  32'd0);
    check("rst_cout", {31'd0, cout8}, 32'd0);
    rst_n = 1'b1;
    tick();

    do_op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    do_op8(8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1);
    do_op8(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0);
    do_op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    do_op8(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0);
    do_op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    do_op8(8'h96, 8'h2B, 1'b1, 8'hC2, 1'b0);

    // Reset lands on the fourth edge after acceptance.
    do_op8(8'hC3, 8'h3C, 1'b1, 8'h00, 1'b1);
    a8 = 8'h55; b8 = 8'h66; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_busy", {31'd0, busy8}, 32'd0);
    check("midrst_done", {31'd0, done8}, 32'd0);
    check("midrst_sum",  {24'd0, sum8},  32'd0);
    check("midrst_cout", {31'd0, cout8}, 32'd0);
    rst_n = 1'b1;
    pulses = 0;
    repeat (15) begin
      tick();
      if (done8) pulses++;
    end
    check("midrst_no_done", pulses, 0);
    do_op8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0);

    // Start held high, operands churn every cycle; the model tracks which
    // operands each accepting edge captured. Each op spans WIDTH+1 busy
    // edges plus the one IDLE edge on which the next start is accepted.
    start8 = 1'b1;
    last = -1;
    pulses = 0;
    for (int k = 0; k < 45; k++) begin
      a8 = 8'(k * 37 + 3);
      b8 = 8'(k * 53 + 11);
      cin8 = k[0];
      tick();
      if (done8) begin
        if (last >= 0) check("held_period", k - last, W8 + 2);
        last = k;
        pulses++;
      end
    end
    check("held_pulses", {31'd0, pulses >= 3}, 32'd1);
    start8 = 1'b0;
    wait_done8(n);
    tick();
    check("held_idle", {31'd0, busy8}, 32'd0);

    // Exhaustive 4-bit sweep.
    for (int i = 0; i < 512; i++) begin
      logic [4:0] exp4;
      a4 = i[3:0]; b4 = i[7:4]; cin4 = i[8];
      exp4 = {1'b0, i[3:0]} + {1'b0, i[7:4]} + {4'd0, i[8]};
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      a4 = ~a4; b4 = ~b4;
      n = 0;
      while (!done4 && n < 20) begin
        tick();
        n++;
      end
      check("w4_latency", n, W4);
      check("w4_result", {27'd0, cout4, sum4}, {27'd0, exp4});
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
